decimate_pcm_3: RTL and testbench

DECIMATE_PCM_3 -- requirements
Module: decimate_pcm_3

---
 rtl/decimate_pcm_3_pkg.sv | 30 +++
 rtl/hb7_mac_pcm.sv | 79 +++++++
 rtl/decimate_pcm_3.sv | 131 +++++++++++++
 tb/tb_decimate_pcm_3.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/decimate_pcm_3_pkg.sv
// Shared constants and types for the decimate_pcm_3 halfband decimator.
// Build option: define DECIMATE_PCM_3_SAT_EN to clamp outputs instead of wrapping.
package decimate_pcm_3_pkg;

  // Halfband taps scaled by 32: h = {-1, 0, 9, 16, 9, 0, -1}
  localparam int COEF_EDGE   = -1;
  localparam int COEF_NEAR   = 9;
  localparam int COEF_CENTER = 16;

  // Accumulator guard bits over the sample width (ACC_W = DW + 6)
  localparam int unsigned ACC_GUARD   = 6;
  // Coefficient scale is 2^5; rounding adds half an LSB before the shift
  localparam int unsigned ROUND_SHIFT = 5;
  localparam int unsigned ROUND_BIAS  = 16;

  // One state per clock of the MAC sequence
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MAC0  = 3'd1,
    ST_MAC1  = 3'd2,
    ST_MAC2  = 3'd3,
    ST_ROUND = 3'd4
  } state_t;

  // ACC_W for a given sample width
  function automatic int unsigned acc_width(input int unsigned dw);
    return dw + ACC_GUARD;
  endfunction

endpackage

// File: rtl/hb7_mac_pcm.sv
// Halfband MAC datapath: pair adds, accumulator, round-half-up and output reduction.
// Build option: DECIMATE_PCM_3_SAT_EN selects clamping; otherwise results wrap to DW bits.
module hb7_mac_pcm
  import decimate_pcm_3_pkg::*;
#(
  parameter int unsigned DW = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  state_t               state_i,
  input  logic signed [DW-1:0] x0_i,
  input  logic signed [DW-1:0] x2_i,
  input  logic signed [DW-1:0] x3_i,
  input  logic signed [DW-1:0] x4_i,
  input  logic signed [DW-1:0] x6_i,
  output logic signed [DW-1:0] y_c_o
);

  localparam int unsigned ACC_W = acc_width(DW);
  localparam int unsigned SUM_W = DW + 1;
  localparam int unsigned Y_W   = ACC_W - ROUND_SHIFT;

  logic signed [SUM_W-1:0] sum_edge_c;
  logic signed [SUM_W-1:0] sum_near_c;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;
  logic signed [ACC_W-1:0] rnd_c;
  logic signed [Y_W-1:0]   y_full_c;
  logic                    unused_bits_c;

  // Symmetric pair sums and the per-state accumulator update
  always_comb begin
    sum_edge_c = SUM_W'(x0_i) + SUM_W'(x6_i);
    sum_near_c = SUM_W'(x2_i) + SUM_W'(x4_i);
    acc_d      = acc_q;
    case (state_i)
      ST_MAC0: acc_d = ACC_W'(COEF_EDGE) * ACC_W'(sum_edge_c);
      ST_MAC1: acc_d = acc_q + ACC_W'(COEF_NEAR) * ACC_W'(sum_near_c);
      ST_MAC2: acc_d = acc_q + ACC_W'(COEF_CENTER) * ACC_W'(x3_i);
      default: acc_d = acc_q;
    endcase
  end

  // Accumulator register; MAC0 overwrites, so a restart needs no explicit clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  // Round half up, then arithmetic shift by the coefficient scale
  always_comb begin
    rnd_c    = acc_q + ACC_W'(ROUND_BIAS);
    y_full_c = rnd_c[ACC_W-1:ROUND_SHIFT];
  end

`ifdef DECIMATE_PCM_3_SAT_EN
  // Clamp to the DW-bit range when the upper bits are not a pure sign extension
  always_comb begin
    if ((y_full_c[Y_W-1:DW-1] == '0) || (y_full_c[Y_W-1:DW-1] == '1)) begin
      y_c_o = y_full_c[DW-1:0];
    end else if (y_full_c[Y_W-1]) begin
      y_c_o = {1'b1, {(DW-1){1'b0}}};
    end else begin
      y_c_o = {1'b0, {(DW-1){1'b1}}};
    end
  end

  assign unused_bits_c = ^rnd_c[ROUND_SHIFT-1:0];
`else
  // Two's-complement wrap: keep the low DW bits
  assign y_c_o = y_full_c[DW-1:0];

  assign unused_bits_c = ^{rnd_c[ROUND_SHIFT-1:0], y_full_c[Y_W-1:DW]};
`endif

endmodule

// File: rtl/decimate_pcm_3.sv
// Halfband 7-tap FIR decimate-by-2 for two's-complement PCM.
// Holds the delay line, phase, snapshot, sequencing FSM and status flags;
// arithmetic lives in hb7_mac_pcm.
// Build option: define DECIMATE_PCM_3_SAT_EN to clamp out-of-range results.
module decimate_pcm_3
  import decimate_pcm_3_pkg::*;
#(
  parameter int unsigned DW      = 24,
  parameter int unsigned MIN_GAP = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic signed [DW-1:0] in,
  output logic signed [DW-1:0] out,
  output logic                 out_valid,
  output logic                 busy,
  output logic                 overrun
);

  localparam int unsigned LINE_LEN = 6;

  // Enable spacing is a usage contract only; the block never measures it
  localparam int unsigned unused_min_gap = MIN_GAP;

  // x_q[k] holds tap x[k+1] as seen after the next shift; the x6 tap only
  // ever matters at snapshot time, so it lives in snap_x6_q alone
  logic signed [DW-1:0] x_q [LINE_LEN];
  logic                 phase_q;

  logic signed [DW-1:0] snap_x0_q;
  logic signed [DW-1:0] snap_x2_q;
  logic signed [DW-1:0] snap_x3_q;
  logic signed [DW-1:0] snap_x4_q;
  logic signed [DW-1:0] snap_x6_q;

  state_t               state_q;
  logic signed [DW-1:0] out_q;
  logic                 out_valid_q;
  logic                 busy_q;
  logic                 overrun_q;

  logic                 start_c;
  logic signed [DW-1:0] y_c;

  assign start_c = enable & phase_q;

  // Delay line shift and phase toggle on every input strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LINE_LEN; i++) begin
        x_q[i] <= '0;
      end
      phase_q <= 1'b0;
    end else if (enable) begin
      x_q[0] <= in;
      for (int i = 1; i < LINE_LEN; i++) begin
        x_q[i] <= x_q[i-1];
      end
      phase_q <= ~phase_q;
    end
  end

  // Sequencer: snapshot post-shift taps on a kept-phase strobe, then walk MAC0..ROUND
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_x0_q   <= '0;
      snap_x2_q   <= '0;
      snap_x3_q   <= '0;
      snap_x4_q   <= '0;
      snap_x6_q   <= '0;
      state_q     <= ST_IDLE;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      if (start_c) begin
        // A start always wins: any sequence in flight is dropped without output
        snap_x0_q <= in;
        snap_x2_q <= x_q[1];
        snap_x3_q <= x_q[2];
        snap_x4_q <= x_q[3];
        snap_x6_q <= x_q[5];
        state_q   <= ST_MAC0;
        busy_q    <= 1'b1;
        if (state_q != ST_IDLE) begin
          overrun_q <= 1'b1;
        end
      end else begin
        case (state_q)
          ST_IDLE:  state_q <= ST_IDLE;
          ST_MAC0:  state_q <= ST_MAC1;
          ST_MAC1:  state_q <= ST_MAC2;
          ST_MAC2:  state_q <= ST_ROUND;
          ST_ROUND: begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            out_q       <= y_c;
            out_valid_q <= 1'b1;
          end
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  hb7_mac_pcm #(
    .DW (DW)
  ) u_mac (
    .clk     (clk),
    .rst     (rst),
    .state_i (state_q),
    .x0_i    (snap_x0_q),
    .x2_i    (snap_x2_q),
    .x3_i    (snap_x3_q),
    .x4_i    (snap_x4_q),
    .x6_i    (snap_x6_q),
    .y_c_o   (y_c)
  );

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_decimate_pcm_3.sv
// Directed bench for decimate_pcm_3: vector table plus overrun, busy-shift and reset corner cases.
module tb_decimate_pcm_3;

  localparam int unsigned DW = 24;
  localparam int          M  = 8388607;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 enable;
  logic signed [DW-1:0] in_s;
  logic signed [DW-1:0] out_s;
  logic                 out_valid;
  logic                 busy;
  logic                 overrun;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic do_rst;
    int   sample;
    logic chk;
    int   exp;
  } vec_t;

  vec_t vecs[$];

  decimate_pcm_3 #(
    .DW      (DW),
    .MIN_GAP (6)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .in        (in_s),
    .out       (out_s),
    .out_valid (out_valid),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic void add(input logic r, input int s, input logic c, input int e);
    vec_t v;
    v.do_rst = r;
    v.sample = s;
    v.chk    = c;
    v.exp    = e;
    vecs.push_back(v);
  endfunction

  // All tasks start and end at a falling edge
  task automatic do_reset();
    rst    = 1'b1;
    enable = 1'b0;
    in_s   = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse(input int v);
    enable = 1'b1;
    in_s   = DW'(v);
    @(negedge clk);
    enable = 1'b0;
    in_s   = '0;
  endtask

  task automatic idle_no_valid(input string name, input int n);
    int cnt;
    cnt = 0;
    repeat (n) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    check(name, longint'(cnt), 0);
  endtask

  // Called at the falling edge right after the start edge N
  task automatic expect_out(input string name, input int exp);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) check({name, "_busy"}, longint'(busy), 1);
      if (k == 3) check({name, "_early"}, longint'(out_valid), 0);
      if (k == 4) begin
        check({name, "_valid"}, longint'(out_valid), 1);
        check(name, longint'(out_s), longint'(exp));
        check({name, "_idle"}, longint'(busy), 0);
      end
      if (k == 5) check({name, "_pulse"}, longint'(out_valid), 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ovs;
    int cnt;
    int pos;
    int val;

`ifdef DECIMATE_PCM_3_SAT_EN
    ovs = 8388607;
`else
    ovs = -8126465;
`endif

    // DC 100000, spacing 8
    add(1, 100000, 0, 0);      add(0, 100000, 1, -3125);
    add(0, 100000, 0, 0);      add(0, 100000, 1, 75000);
    add(0, 100000, 0, 0);      add(0, 100000, 1, 103125);
    add(0, 100000, 0, 0);      add(0, 100000, 1, 100000);
    add(0, 100000, 0, 0);      add(0, 100000, 1, 100000);
    // Impulse landing on the kept phase
    add(1, 0, 0, 0);           add(0, 32768, 1, -1024);
    add(0, 0, 0, 0);           add(0, 0, 1, 9216);
    add(0, 0, 0, 0);           add(0, 0, 1, 9216);
    add(0, 0, 0, 0);           add(0, 0, 1, -1024);
    add(0, 0, 0, 0);           add(0, 0, 1, 0);
    // Impulse landing on the dropped phase
    add(1, 32768, 0, 0);       add(0, 0, 1, 0);
    add(0, 0, 0, 0);           add(0, 0, 1, 16384);
    add(0, 0, 0, 0);           add(0, 0, 1, 0);
    // Full-scale step: overshoot on the third output
    add(1, M, 0, 0);           add(0, M, 1, -262144);
    add(0, M, 0, 0);           add(0, M, 1, 6291455);
    add(0, M, 0, 0);           add(0, M, 1, ovs);
    add(0, M, 0, 0);           add(0, M, 1, 8388607);

    rst    = 1'b1;
    enable = 1'b0;
    in_s   = '0;
    repeat (3) @(negedge clk);
    check("rst_out", longint'(out_s), 0);
    check("rst_valid", longint'(out_valid), 0);
    check("rst_busy", longint'(busy), 0);
    check("rst_overrun", longint'(overrun), 0);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      if (vecs[i].do_rst) do_reset();
      pulse(vecs[i].sample);
      if (vecs[i].chk) begin
        expect_out($sformatf("vec%0d_out", i), vecs[i].exp);
        @(negedge clk);
        @(negedge clk);
      end else begin
        idle_no_valid($sformatf("vec%0d_novalid", i), 7);
      end
    end
    check("no_overrun_spaced", longint'(overrun), 0);

    // Phase-0 strobe during busy shifts the line but leaves the snapshot alone
    do_reset();
    pulse(32);
    @(negedge clk);
    repeat (6) @(negedge clk);
    pulse(64);
    @(negedge clk);
    pulse(3200);
    for (int k = 3; k <= 5; k++) begin
      @(negedge clk);
      if (k == 4) begin
        check("busyshift_valid", longint'(out_valid), 1);
        check("busyshift_out", longint'(out_s), -2);
      end
      if (k == 5) check("busyshift_pulse", longint'(out_valid), 0);
    end
    check("busyshift_no_overrun", longint'(overrun), 0);

    // Two starts two clocks apart: one output, from the second snapshot
    do_reset();
    enable = 1'b1;
    in_s   = DW'(32);
    @(negedge clk);
    in_s = DW'(64);
    @(negedge clk);
    in_s = '0;
    @(negedge clk);
    in_s = '0;
    @(negedge clk);
    enable = 1'b0;
    check("overrun_set", longint'(overrun), 1);
    cnt = 0;
    pos = 0;
    val = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (out_valid) begin
        cnt++;
        pos = k;
        val = int'(out_s);
      end
    end
    check("overrun_valid_count", longint'(cnt), 1);
    check("overrun_valid_pos", longint'(pos), 4);
    check("overrun_out", longint'(val), 34);
    repeat (20) @(negedge clk);
    check("overrun_sticky", longint'(overrun), 1);

    // Reset during MAC1 aborts with no output; restart needs two new strobes
    do_reset();
    pulse(3200);
    repeat (7) @(negedge clk);
    pulse(3200);
    expect_out("prerst_out", -100);
    @(negedge clk);
    @(negedge clk);
    pulse(0);
    repeat (7) @(negedge clk);
    pulse(0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", longint'(busy), 0);
    check("midrst_out", longint'(out_s), 0);
    check("midrst_valid", longint'(out_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    idle_no_valid("midrst_abort_novalid", 8);
    pulse(32);
    idle_no_valid("midrst_first_strobe_novalid", 7);
    pulse(64);
    expect_out("postrst_out", -2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
